// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the fetch stage's instruction-memory, redirect and
// decode handoff signals.
//   master : the fetch stage. It drives imem_req_valid/addr and id_valid/inst/pc/pc4,
//            and samples imem_req_ready, imem_rsp_valid/data, redirect/redirect_pc and id_ready.
//   slave  : the environment, meaning the memory, control and decode. Directions are mirrored.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, id_pc4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc, id_pc4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: rv32 instruction fetch. This block owns the PC and issues in-order word
// requests to instruction memory. Returned words and their PCs are buffered in a
// DEPTH-entry FIFO and handed to decode over valid/ready. A redirect flushes all
// in-flight work and restarts fetch at the target.
// Ports:
//   clk, rst : clock and synchronous active-high reset.
//   bus      : fetch_stage_if.master. It carries the imem request/response, the redirect
//              and the id_* handoff.
// Optional build macro FETCH_NOP_FILL_EN: while id_valid is low, id_inst, id_pc and
// id_pc4 read 32'h13, 0 and 4. Without it they hold the last head value.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};
`ifdef FETCH_NOP_FILL_EN
    localparam logic [31:0] IDLE_INST = 32'h0000_0013;
`else
    localparam logic [31:0] IDLE_INST = 32'h0000_0000;
`endif

    logic [31:0]   pc_q, pc_n;
    logic [31:0]   rsp_pc_q, rsp_pc_n;
    logic [CW-1:0] out_q, out_n;
    logic [CW-1:0] drop_q, drop_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_kept;
    logic [AW-1:0] rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          req_en_q;
    logic          id_valid_q, id_valid_n;
    logic [31:0]   id_inst_q, id_inst_n;
    logic [31:0]   id_pc_q, id_pc_n;
    logic [31:0]   id_pc4_q, id_pc4_n;
    logic [31:0]   redir_pc;
    logic          room, req_fire, rsp_fire, push, pop;
    logic          unused_redir_lsb;

    assign redir_pc         = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb = ^bus.redirect_pc[1:0];

    // Capacity counts requests in flight, including ones that will be dropped, plus buffered words.
    assign room     = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_W;
    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = bus.imem_rsp_valid & (out_q != '0);
    assign push     = rsp_fire & (drop_q == '0) & ~bus.redirect;
    assign pop      = id_valid_q & bus.id_ready & ~bus.redirect;
    assign cnt_kept = cnt_q - CW'(pop);

    assign bus.imem_req_valid = req_en_q & ~rst & ~bus.redirect & room;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_inst        = id_inst_q;
    assign bus.id_pc          = id_pc_q;
    assign bus.id_pc4         = id_pc4_q;

    // PC, counters and FIFO pointers.
    // Responses come back in request order, and requests since the last restart are
    // sequential. So the in-flight PC queue reduces to the PC of the next kept response.
    always_comb begin
        pc_n     = pc_q;
        rsp_pc_n = rsp_pc_q;
        out_n    = out_q + CW'(req_fire) - CW'(rsp_fire);
        drop_n   = drop_q;
        cnt_n    = cnt_q;
        rd_ptr_n = rd_ptr_q;
        wr_ptr_n = wr_ptr_q;
        if (bus.redirect) begin
            pc_n     = redir_pc;
            rsp_pc_n = redir_pc;
            drop_n   = out_n;
            cnt_n    = '0;
            rd_ptr_n = '0;
            wr_ptr_n = '0;
        end else begin
            if (req_fire) begin
                pc_n = pc_q + 32'd4;
            end
            if (push) begin
                rsp_pc_n = rsp_pc_q + 32'd4;
            end
            if (rsp_fire && (drop_q != '0)) begin
                drop_n = drop_q - CW'(1);
            end
            cnt_n    = cnt_q + CW'(push) - CW'(pop);
            rd_ptr_n = rd_ptr_q + AW'(pop);
            wr_ptr_n = wr_ptr_q + AW'(push);
        end
    end

    // Next head of the FIFO. If the FIFO drains to just this cycle's response, that word becomes the head.
    always_comb begin
        id_valid_n = (cnt_n != '0);
        id_inst_n  = id_inst_q;
        id_pc_n    = id_pc_q;
        id_pc4_n   = id_pc4_q;
        if (id_valid_n) begin
            if (cnt_kept == '0) begin
                id_inst_n = bus.imem_rsp_data;
                id_pc_n   = rsp_pc_q;
            end else begin
                id_inst_n = inst_mem[rd_ptr_n];
                id_pc_n   = pc_mem[rd_ptr_n];
            end
            id_pc4_n = id_pc_n + 32'd4;
        end
`ifdef FETCH_NOP_FILL_EN
        else begin
            id_inst_n = IDLE_INST;
            id_pc_n   = 32'd0;
            id_pc4_n  = 32'd4;
        end
`endif
    end

    // State registers.
    // Reset keeps the in-flight count as the drop count, because memory will still
    // answer requests issued before the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= BOOT_PC;
            rsp_pc_q   <= BOOT_PC;
            out_q      <= out_q - CW'(rsp_fire);
            drop_q     <= out_q - CW'(rsp_fire);
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            req_en_q   <= 1'b0;
            id_valid_q <= 1'b0;
            id_inst_q  <= IDLE_INST;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd4;
        end else begin
            pc_q       <= pc_n;
            rsp_pc_q   <= rsp_pc_n;
            out_q      <= out_n;
            drop_q     <= drop_n;
            cnt_q      <= cnt_n;
            rd_ptr_q   <= rd_ptr_n;
            wr_ptr_q   <= wr_ptr_n;
            req_en_q   <= 1'b1;
            id_valid_q <= id_valid_n;
            id_inst_q  <= id_inst_n;
            id_pc_q    <= id_pc_n;
            id_pc4_q   <= id_pc4_n;
        end
    end

    // FIFO storage. The count and pointers qualify the contents, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= bus.imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the rv32 pipeline, directly upstream of decode/control.
- Owns the PC register and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO with their PCs and presents them to decode via valid/ready.
- Consumes the redirect (pcSel plus target) from the control/branch path, flushes in-flight work and restarts fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, fetch buffer entries; also the maximum outstanding plus buffered requests (power of 2, 2..8).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
imem_req_valid  output  1  request to instruction memory.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
imem_rsp_valid  input  1  response valid; responses return in request order, latency at least 1 cycle.
imem_rsp_data  input  32  instruction word.
redirect  input  1  pcSel from control: taken branch or jump.
redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
id_valid  output  1  id_inst and id_pc hold a valid instruction.
id_ready  input  1  decode consumes the head this cycle; low means stall.
id_inst  output  32  instruction to control/decode.
id_pc  output  32  PC of id_inst.
id_pc4  output  32  id_pc + 4, wraps modulo 2^32.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop count=0.
  - Outputs: imem_req_valid=0 in the cycle after reset; id_valid=0; id_inst=0 (or NOP, see feature); id_pc=0; id_pc4=4.
  - Reset mid-operation discards everything. Responses to pre-reset requests arriving after reset are ignored via drop count = outstanding at reset.
- Request issue: imem_req_valid=1 when rst=0, redirect=0 and (outstanding + fifo_count) < DEPTH.
  - imem_req_addr=pc.
  - On valid&ready: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), outstanding increments, and the request PC is pushed into an internal in-flight PC queue.
- Response: on imem_rsp_valid with drop count 0, pop the in-flight PC and push {pc, data} into the FIFO. Outstanding decrements.
  - Capacity rule guarantees no overflow. A response while outstanding=0 is a protocol error and is ignored.
- Dropped responses: if drop count > 0, imem_rsp_valid decrements the drop count and outstanding; data is discarded.
- Decode handoff: id_valid = FIFO not empty; id_inst/id_pc = FIFO head.
  - Head pops when id_valid & id_ready.
  - Push and pop in the same cycle are allowed, including when full, since capacity is checked before issue.
  - No bypass: a response is visible on id_* the cycle after it arrives (minimum fetch-to-decode latency is 2 cycles from request accept).
- Redirect, highest priority below reset:
  - In the redirect cycle: imem_req_valid=0.
  - At the edge: pc <= {redirect_pc[31:2],2'b00}; FIFO cleared; in-flight PC queue cleared.
  - Drop count <= outstanding after this cycle's response is applied. A response arriving in the redirect cycle is discarded.
  - id_ready in the redirect cycle is don't-care; the head is flushed, not popped.
  - Next cycle: request issues at the target if capacity allows; id_valid=0.
- Back-to-back redirects: each overwrites pc and accumulates drops correctly; drop count never exceeds DEPTH.
- Stall (id_ready=0) holds the head and all id_* outputs stable. Fetch continues until outstanding + fifo_count = DEPTH, then imem_req_valid=0.

Optional Feature:
FETCH_NOP_FILL_EN.
- Defined: when id_valid=0, id_inst = 32'h0000_0013 (addi x0,x0,0), id_pc=0 and id_pc4=4, so combinational decode of a bubble produces no side effects.
- Undefined: when id_valid=0, id_inst=0 (after reset) or holds the last popped/flushed head value; consumers must qualify with id_valid.

Test Plan:
1. Reset with RESET_PC=32'h0000_0100, imem_req_ready=1, fixed 1-cycle response latency -> addresses 0x100, 0x104, 0x108 issued on consecutive cycles; id_pc=0x100 with id_pc4=0x104 appears 2 cycles after the first accept.
2. Hold id_ready=0 with DEPTH=2 -> exactly 2 requests issued then imem_req_valid=0; id_inst and id_pc stable; releasing id_ready resumes fetch one cycle later.
3. Redirect to 0x0000_0203 with 1 outstanding request and 1 entry buffered -> next request addr 0x200; the in-flight response is dropped; first id_pc after the redirect = 0x200.
4. Response and redirect in the same cycle -> that response is never presented on id_*; drop count handles the remaining outstanding response.
5. PC at 0xFFFF_FFFC -> next request addr 0x0000_0000; id_pc4 for that instruction = 0.
6. Assert rst with 2 requests outstanding, then deliver both responses after reset -> both discarded; fetch restarts at RESET_PC; with FETCH_NOP_FILL_EN, id_inst=0x0000_0013 while id_valid=0.
